// File: rtl/serializer_stream_if.sv
// serializer_stream_if: word-in / bit-out bundle for serializer_stream
//   din, din_valid   : producer word and its valid flag
//   din_ready        : serializer can take din this cycle
//   dout, dout_valid : serial bit and its valid flag
//   sof, eof, busy   : first bit, last bit, serializer not idle
// modport master is the producer/observer side; modport slave is the serializer side.
interface serializer_stream_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              dout;
    logic              dout_valid;
    logic              sof;
    logic              eof;
    logic              busy;
    modport master (output din, din_valid, input din_ready, dout, dout_valid, sof, eof, busy);
    modport slave  (input din, din_valid, output din_ready, dout, dout_valid, sof, eof, busy);
endinterface

// File: rtl/serializer_stream.sv
// serializer_stream: DATA_W-bit valid/ready words in, one registered bit per clk out
//   clk, rst : clock, asynchronous active-high reset
//   bus      : serializer_stream_if.slave (din/din_valid/din_ready, dout/dout_valid/sof/eof/busy)
// Define SERIALIZER_STREAM_PARITY_EN to append an even-parity bit after each word.
module serializer_stream #(
    parameter int DATA_W    = 32,
    parameter bit MSB_FIRST = 1'b0,
    parameter int GAP_CYC   = 0,
    parameter bit IDLE_LVL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    serializer_stream_if.slave bus
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic [7:0] GAP_END = 8'(GAP_CYC - 1);
`ifdef SERIALIZER_STREAM_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;
    logic par;
`else
    localparam logic [CW-1:0] PRE = CW'(DATA_W - 2);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif
    state_t state;
    logic [DATA_W-1:0] sh;
    logic [CW-1:0] cnt;
    logic [7:0] gcnt;
    logic dout, dout_valid, sof, eof, ready, last, load;
    function automatic logic pick(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction
    function automatic logic [DATA_W-1:0] shift(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction
    // last: the cycle currently showing the final bit of the word
`ifdef SERIALIZER_STREAM_PARITY_EN
    assign last = state == PAR;
`else
    assign last = state == SHIFT && cnt == LAST;
`endif
    assign ready = !rst && (state == IDLE || (last && GAP_CYC == 0));
    assign load  = bus.din_valid && ready;
    assign bus.din_ready  = ready;
    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.sof        = sof;
    assign bus.eof        = eof;
    assign bus.busy       = state != IDLE;
    // dout holds the bit being shown; sh holds the bits still to come
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sh         <= '0;
            cnt        <= '0;
            gcnt       <= '0;
            dout       <= IDLE_LVL;
            dout_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
`ifdef SERIALIZER_STREAM_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            sof <= 1'b0;
            eof <= 1'b0;
            if (load) begin
                state      <= SHIFT;
                sh         <= shift(bus.din);
                cnt        <= '0;
                dout       <= pick(bus.din);
                dout_valid <= 1'b1;
                sof        <= 1'b1;
`ifdef SERIALIZER_STREAM_PARITY_EN
                par        <= ^bus.din;
`endif
            end else if (last) begin
                state      <= GAP_CYC > 0 ? GAP : IDLE;
                gcnt       <= '0;
                dout       <= IDLE_LVL;
                dout_valid <= 1'b0;
            end else if (state == SHIFT) begin
`ifdef SERIALIZER_STREAM_PARITY_EN
                if (cnt == LAST) begin
                    state <= PAR;
                    dout  <= par;
                    eof   <= 1'b1;
                end else
`endif
                begin
                    sh   <= shift(sh);
                    dout <= pick(sh);
                    cnt  <= cnt + CW'(1);
`ifndef SERIALIZER_STREAM_PARITY_EN
                    eof  <= cnt == PRE;
`endif
                end
            end else if (state == GAP) begin
                if (gcnt == GAP_END) state <= IDLE;
                else gcnt <= gcnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_serializer_stream.sv
// tb_serializer_stream: directed checks of serializer_stream in LSB-first, MSB-first and gapped builds
module tb_serializer_stream;
`ifdef SERIALIZER_STREAM_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    typedef struct {
        logic [7:0] din;
        logic [7:0] lsb;
        logic [7:0] msb;
        logic       par;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] din_g = 8'h00;
    logic vld = 1'b0;
    logic vld_g = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    serializer_stream_if #(.DATA_W(8)) if_l ();
    serializer_stream_if #(.DATA_W(8)) if_m ();
    serializer_stream_if #(.DATA_W(8)) if_g ();
    assign if_l.din = din;
    assign if_l.din_valid = vld;
    assign if_m.din = din;
    assign if_m.din_valid = vld;
    assign if_g.din = din_g;
    assign if_g.din_valid = vld_g;
    serializer_stream #(.DATA_W(8), .MSB_FIRST(1'b0), .GAP_CYC(0), .IDLE_LVL(1'b0))
        u_lsb (.clk(clk), .rst(rst), .bus(if_l.slave));
    serializer_stream #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP_CYC(0), .IDLE_LVL(1'b0))
        u_msb (.clk(clk), .rst(rst), .bus(if_m.slave));
    serializer_stream #(.DATA_W(8), .MSB_FIRST(1'b0), .GAP_CYC(3), .IDLE_LVL(1'b1))
        u_gap (.clk(clk), .rst(rst), .bus(if_g.slave));
    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask
    initial begin
        vec_t tbl[6];
        logic [8:0] sl, sm, sg;
        // sequences written first-out on the left
        tbl[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
        tbl[1] = '{8'h0F, 8'b11110000, 8'b00001111, 1'b0};
        tbl[2] = '{8'h07, 8'b11100000, 8'b00000111, 1'b1};
        tbl[3] = '{8'h03, 8'b11000000, 8'b00000011, 1'b0};
        tbl[4] = '{8'h80, 8'b00000001, 8'b10000000, 1'b1};
        tbl[5] = '{8'h6C, 8'b00110110, 8'b01101100, 1'b0};
        repeat (3) @(negedge clk);
        chk("rst ready_l", if_l.din_ready, 1'b0);
        chk("rst ready_g", if_g.din_ready, 1'b0);
        chk("rst dout_l", if_l.dout, 1'b0);
        chk("rst dout_g", if_g.dout, 1'b1);
        chk("rst valid_l", if_l.dout_valid, 1'b0);
        chk("rst busy_l", if_l.busy, 1'b0);
        rst = 1'b0;
        #1;
        chk("post rst ready_l", if_l.din_ready, 1'b1);
        chk("post rst ready_m", if_m.din_ready, 1'b1);
        chk("post rst busy_l", if_l.busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din = tbl[i].din;
            vld = 1'b1;
            chk($sformatf("v%0d ready_l", i), if_l.din_ready, 1'b1);
            chk($sformatf("v%0d ready_m", i), if_m.din_ready, 1'b1);
            @(posedge clk);
            @(negedge clk);
            vld = 1'b0;
            din = ~din;
            sl = {tbl[i].lsb, tbl[i].par};
            sm = {tbl[i].msb, tbl[i].par};
            for (int k = 0; k < NB; k++) begin
                chk($sformatf("v%0d b%0d dout_l", i, k), if_l.dout, sl[8-k]);
                chk($sformatf("v%0d b%0d dout_m", i, k), if_m.dout, sm[8-k]);
                chk($sformatf("v%0d b%0d valid_l", i, k), if_l.dout_valid, 1'b1);
                chk($sformatf("v%0d b%0d valid_m", i, k), if_m.dout_valid, 1'b1);
                chk($sformatf("v%0d b%0d sof_l", i, k), if_l.sof, k == 0);
                chk($sformatf("v%0d b%0d eof_m", i, k), if_m.eof, k == NB - 1);
                chk($sformatf("v%0d b%0d eof_l", i, k), if_l.eof, k == NB - 1);
                @(negedge clk);
            end
            chk($sformatf("v%0d end valid_l", i), if_l.dout_valid, 1'b0);
            chk($sformatf("v%0d end dout_l", i), if_l.dout, 1'b0);
            chk($sformatf("v%0d end busy_m", i), if_m.busy, 1'b0);
        end
        @(negedge clk);
        din = 8'hA5;
        vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid busy_l", if_l.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid rst dout_l", if_l.dout, 1'b0);
        chk("mid rst valid_l", if_l.dout_valid, 1'b0);
        chk("mid rst ready_l", if_l.din_ready, 1'b0);
        chk("mid rst sof_l", if_l.sof, 1'b0);
        chk("mid rst eof_l", if_l.eof, 1'b0);
        chk("mid rst busy_l", if_l.busy, 1'b0);
        chk("mid rst dout_g", if_g.dout, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid rel ready_l", if_l.din_ready, 1'b1);
        chk("mid rel busy_l", if_l.busy, 1'b0);
        repeat (10) @(negedge clk);
        chk("mid no resume valid_l", if_l.dout_valid, 1'b0);
        chk("mid no resume busy_l", if_l.busy, 1'b0);
        din = 8'hFF;
        vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din = 8'h00;
        for (int k = 0; k < 2 * NB; k++) begin
            if (k == NB) vld = 1'b0;
            chk($sformatf("str %0d dout_l", k), if_l.dout, k < 8);
            chk($sformatf("str %0d dout_m", k), if_m.dout, k < 8);
            chk($sformatf("str %0d valid_l", k), if_l.dout_valid, 1'b1);
            chk($sformatf("str %0d sof_l", k), if_l.sof, k == 0 || k == NB);
            chk($sformatf("str %0d eof_l", k), if_l.eof, k == NB - 1 || k == 2 * NB - 1);
            chk($sformatf("str %0d ready_l", k), if_l.din_ready, k == NB - 1 || k == 2 * NB - 1);
            @(negedge clk);
        end
        chk("str end valid_l", if_l.dout_valid, 1'b0);
        chk("str end busy_l", if_l.busy, 1'b0);
        din_g = 8'h81;
        vld_g = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din_g = 8'h42;
        for (int w = 0; w < 2; w++) begin
            sg = w == 0 ? 9'b0_1000_0001 : 9'b0_0100_0010;
            for (int k = 0; k < NB; k++) begin
                chk($sformatf("gap w%0d b%0d dout", w, k), if_g.dout, sg[k]);
                chk($sformatf("gap w%0d b%0d valid", w, k), if_g.dout_valid, 1'b1);
                chk($sformatf("gap w%0d b%0d sof", w, k), if_g.sof, k == 0);
                chk($sformatf("gap w%0d b%0d eof", w, k), if_g.eof, k == NB - 1);
                chk($sformatf("gap w%0d b%0d ready", w, k), if_g.din_ready, 1'b0);
                @(negedge clk);
            end
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("gap w%0d g%0d valid", w, g), if_g.dout_valid, 1'b0);
                chk($sformatf("gap w%0d g%0d dout", w, g), if_g.dout, 1'b1);
                chk($sformatf("gap w%0d g%0d ready", w, g), if_g.din_ready, 1'b0);
                chk($sformatf("gap w%0d g%0d busy", w, g), if_g.busy, 1'b1);
                @(negedge clk);
            end
            chk($sformatf("gap w%0d idle ready", w), if_g.din_ready, 1'b1);
            chk($sformatf("gap w%0d idle busy", w), if_g.busy, 1'b0);
            chk($sformatf("gap w%0d idle valid", w), if_g.dout_valid, 1'b0);
            chk($sformatf("gap w%0d idle dout", w), if_g.dout, 1'b1);
            if (w == 0) begin
                @(posedge clk);
                @(negedge clk);
                vld_g = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        chk("gap end busy", if_g.busy, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
